tank_bullet: RTL

Projectile engine that consumes a tank's shoot request, position and facing (tank_X, tank_Y, tank_dir, is_shooting) and launches one bullet from the tank's muzzle. It advances the bullet once per frame and retires it at the screen edge or on an external hit. It then enforces a cooldown before the next launch and drives the is_bullet pixel flag for the colour mapper. One instance exists per tank, for both the AI tank and the player tank.

---
 rtl/tank_pkg.sv | 23 ++
 rtl/frame_tick_detect.sv | 24 ++
 rtl/tank_bullet.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// Shared tank/bullet definitions: screen geometry, tank sprite size, facing codes
// and the bullet engine state encoding.
package tank_pkg;

    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MAX = 479;
    localparam int TANK_W       = 32;
    localparam int TANK_H       = 32;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        COOLDOWN
    } bullet_state_t;

endpackage

// File: rtl/frame_tick_detect.sv
// Turns the slow frame clock level into a one-Clk-cycle tick on each rising edge.
module frame_tick_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic r_frameD;
    logic r_tick;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_frameD <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_frameD <= frame_clk;
            r_tick   <= frame_clk & ~r_frameD;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/tank_bullet.sv
// Single-bullet projectile engine: launches from the tank muzzle, moves once per
// frame, retires at the screen edge or on a hit, then waits out a cooldown.
module tank_bullet
    import tank_pkg::*;
#(
    parameter int B_SIZE          = 4,
    parameter int B_STEP          = 4,
    parameter int X_MAX           = SCREEN_X_MAX,
    parameter int Y_MAX           = SCREEN_Y_MAX,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [9:0] tank_X,
    input  logic [9:0] tank_Y,
    input  logic [2:0] tank_dir,
    input  logic       hit,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] bullet_X,
    output logic [9:0] bullet_Y,
    output logic [2:0] bullet_dir,
    output logic       bullet_active,
    output logic       is_bullet
);

    localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

    localparam logic [10:0] L_SIZE  = 11'(B_SIZE);
    localparam logic [10:0] L_STEP  = 11'(B_STEP);
    localparam logic [10:0] L_X_LIM = 11'(X_MAX - B_SIZE + 1);
    localparam logic [10:0] L_Y_LIM = 11'(Y_MAX - B_SIZE + 1);
    localparam logic [10:0] L_X_END = 11'(X_MAX + 1);
    localparam logic [10:0] L_Y_END = 11'(Y_MAX + 1);
    localparam logic [9:0]  OFF_X   = 10'(TANK_W / 2 - B_SIZE / 2);
    localparam logic [9:0]  OFF_Y   = 10'(TANK_H / 2 - B_SIZE / 2);

    logic w_tick;

    frame_tick_detect u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (w_tick)
    );

    bullet_state_t r_state, w_stateNext;
    logic [9:0]    r_bulletX, r_bulletY, w_bulletXNext, w_bulletYNext;
    logic [2:0]    r_bulletDir, w_bulletDirNext;
    logic [CW-1:0] r_cool, w_coolNext;

    logic [9:0]  w_spawnX, w_spawnY;
    logic [10:0] w_farRight, w_farDown;
    logic        w_spawnOk;
    logic [10:0] w_edgeRight, w_edgeDown;
    logic [9:0]  w_stepX, w_stepY;
    logic        w_leave;

    // Muzzle position; limit checks run on 11-bit sums so an off-screen spawn cannot wrap into range.
    always_comb begin
        w_farRight = {1'b0, tank_X} + 11'(TANK_W);
        w_farDown  = {1'b0, tank_Y} + 11'(TANK_H);
        w_spawnX   = tank_X + OFF_X;
        w_spawnY   = tank_Y + OFF_Y;
        w_spawnOk  = 1'b0;
        case (tank_dir)
            DIR_UP: begin
                w_spawnY  = tank_Y - 10'(B_SIZE);
                w_spawnOk = ({1'b0, tank_Y} >= L_SIZE);
            end
            DIR_DOWN: begin
                w_spawnY  = w_farDown[9:0];
                w_spawnOk = (w_farDown <= L_Y_LIM);
            end
            DIR_RIGHT: begin
                w_spawnX  = w_farRight[9:0];
                w_spawnOk = (w_farRight <= L_X_LIM);
            end
            DIR_LEFT: begin
                w_spawnX  = tank_X - 10'(B_SIZE);
                w_spawnOk = ({1'b0, tank_X} >= L_SIZE);
            end
            default: w_spawnOk = 1'b0;
        endcase
    end

    always_comb begin
        w_edgeRight = {1'b0, r_bulletX} + L_SIZE + L_STEP;
        w_edgeDown  = {1'b0, r_bulletY} + L_SIZE + L_STEP;
        w_stepX     = r_bulletX;
        w_stepY     = r_bulletY;
        w_leave     = 1'b0;
        case (r_bulletDir)
            DIR_UP: begin
                w_leave = ({1'b0, r_bulletY} < L_STEP);
                w_stepY = r_bulletY - 10'(B_STEP);
            end
            DIR_DOWN: begin
                w_leave = (w_edgeDown > L_Y_END);
                w_stepY = r_bulletY + 10'(B_STEP);
            end
            DIR_RIGHT: begin
                w_leave = (w_edgeRight > L_X_END);
                w_stepX = r_bulletX + 10'(B_STEP);
            end
            DIR_LEFT: begin
                w_leave = ({1'b0, r_bulletX} < L_STEP);
                w_stepX = r_bulletX - 10'(B_STEP);
            end
            default: w_leave = 1'b1;
        endcase
    end

    always_comb begin
        w_stateNext     = r_state;
        w_bulletXNext   = r_bulletX;
        w_bulletYNext   = r_bulletY;
        w_bulletDirNext = r_bulletDir;
        w_coolNext      = r_cool;
        case (r_state)
            IDLE: begin
                if (w_tick && fire && w_spawnOk) begin
                    w_stateNext     = FLYING;
                    w_bulletXNext   = w_spawnX;
                    w_bulletYNext   = w_spawnY;
                    w_bulletDirNext = tank_dir;
                end
            end
            FLYING: begin
                // A hit wins over a coincident tick so the bullet dies where it was struck.
                if (hit || (w_tick && w_leave)) begin
                    w_stateNext = COOLDOWN;
                    w_coolNext  = '0;
                end else if (w_tick) begin
                    w_bulletXNext = w_stepX;
                    w_bulletYNext = w_stepY;
                end
            end
            COOLDOWN: begin
                if (w_tick) begin
                    if (r_cool == CW'(COOLDOWN_FRAMES - 1)) begin
                        w_stateNext = IDLE;
                    end else begin
                        w_coolNext = r_cool + CW'(1);
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_bulletX   <= '0;
            r_bulletY   <= '0;
            r_bulletDir <= '0;
            r_cool      <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_bulletX   <= w_bulletXNext;
            r_bulletY   <= w_bulletYNext;
            r_bulletDir <= w_bulletDirNext;
            r_cool      <= w_coolNext;
        end
    end

    assign bullet_X      = r_bulletX;
    assign bullet_Y      = r_bulletY;
    assign bullet_dir    = r_bulletDir;
    assign bullet_active = (r_state == FLYING);

    assign is_bullet = bullet_active
                     && (DrawX >= r_bulletX) && ({1'b0, DrawX} < {1'b0, r_bulletX} + L_SIZE)
                     && (DrawY >= r_bulletY) && ({1'b0, DrawY} < {1'b0, r_bulletY} + L_SIZE);

endmodule
